// File: rtl/rr_mux4_arbiter.sv
// rr_mux4_arbiter: round-robin arbiter driving the shared 4:1 mux selects, with registered output bit and valid
module rr_mux4_arbiter #(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       I0,
    input  logic       I1,
    input  logic       I2,
    input  logic       I3,
    output logic [3:0] gnt,
    output logic       S0,
    output logic       S1,
    output logic       y,
    output logic       y_valid
);
    typedef enum logic {IDLE, GRANT} state_t;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_BURST - 1);
    state_t state, state_n;
    logic [1:0] ptr, ptr_n, sel, sel_n, off, win;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [3:0] gnt_n, cand, ivec;
    logic [2:0] rot;
    logic y_n, yv_n, own, take;
    assign S0 = sel[0];
    assign S1 = sel[1];
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state   <= IDLE;
            gnt     <= '0;
            sel     <= '0;
            ptr     <= '0;
            cnt     <= '0;
            y       <= 1'b0;
            y_valid <= 1'b0;
        end else begin
            state   <= state_n;
            gnt     <= gnt_n;
            sel     <= sel_n;
            ptr     <= ptr_n;
            cnt     <= cnt_n;
            y       <= y_n;
            y_valid <= yv_n;
        end
    always_comb begin
        ivec    = {I3, I2, I1, I0};
        cand    = (state == GRANT) ? req & ~gnt : req;
        rot     = 3'({cand, cand} >> ptr);
        off     = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
        win     = ptr + off;
        own     = |(req & gnt);
        take    = (state == IDLE) ? |req : (|cand && (!own || cnt == LAST));
        state_n = (take || (state == GRANT && own)) ? GRANT : IDLE;
        gnt_n   = take ? 4'b0001 << win : (state_n == IDLE) ? 4'b0000 : gnt;
        sel_n   = take ? win : (state_n == IDLE) ? 2'd0 : sel;
        ptr_n   = take ? win + 2'd1 : ptr;
        cnt_n   = take ? '0 : (state == GRANT && own && cnt != LAST) ? cnt + CNT_W'(1) : cnt;
        y_n     = (state == GRANT) ? ivec[sel] : y;
        yv_n    = (state == GRANT);
    end
endmodule
